// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding and bus unit codes.
// The unit codes mirror the values the rest of the bus uses for RAM and "no unit".
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic [3:0] RAM_UNIT_CODE  = 4'h2;
    localparam logic [3:0] NONE_UNIT_CODE = 4'h0;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: among unmasked requests, a tie goes
// to the requester that was not granted last.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] cand;

    always_comb begin
        cand      = req & ~mask;
        gnt_valid = |cand;
        gnt_id    = 1'b0;
        if (&cand) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = cand[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the core (port 0) and debug/DMA (port 1).
// Every output is a flop; the RAM sees one driven cycle (ACCESS) per transaction.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         RAM_ADDR_WIDTH = 8,
    parameter logic [3:0] RAM_CODE       = RAM_UNIT_CODE,
    parameter logic [3:0] NONE_CODE      = NONE_UNIT_CODE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [RAM_ADDR_WIDTH-1:0] addr0,
    input  logic [RAM_ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]     wdata0,
    input  logic [DATA_WIDTH-1:0]     wdata1,
    output logic                      ack0,
    output logic                      ack1,
    output logic [DATA_WIDTH-1:0]     rdata0,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     ram_addr_bus,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    output logic                      busy
);

    arb_state_e                state_q, state_d;
    logic                      gnt_q, gnt_d;
    logic                      we_q, we_d;
    logic                      last_gnt_q, last_gnt_d;
    logic                      ack0_q, ack0_d;
    logic                      ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0]     rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]     rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0]     ram_addr_bus_q, ram_addr_bus_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic                      busy_q, busy_d;

    logic [1:0] arb_mask;
    logic       gnt_valid;
    logic       gnt_id;

    // The requester being acked in RESP is masked so a held req cannot be re-granted.
    assign arb_mask = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req       ({req1, req0}),
        .mask      (arb_mask),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        we_d           = we_q;
        last_gnt_d     = last_gnt_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        rdata0_d       = '0;
        rdata1_d       = '0;
        ram_addr_bus_d = '0;
        ram_addr_d     = '0;
        ram_wdata_d    = '0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (gnt_valid) begin
                    state_d     = ST_ACCESS;
                    gnt_d       = gnt_id;
                    last_gnt_d  = gnt_id;
                    we_d        = gnt_id ? we1 : we0;
                    ram_addr_d  = gnt_id ? addr1 : addr0;
                    ram_wdata_d = gnt_id ? wdata1 : wdata0;
                    ram_addr_bus_d = (gnt_id ? we1 : we0)
                                   ? DATA_WIDTH'({NONE_CODE, RAM_CODE})
                                   : DATA_WIDTH'({RAM_CODE, NONE_CODE});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // RAM read data is combinational, so it is captured as ACCESS ends.
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (gnt_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = we_q ? '0 : ram_rdata;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = we_q ? '0 : ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            gnt_q          <= 1'b0;
            we_q           <= 1'b0;
            last_gnt_q     <= 1'b1;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            ram_addr_bus_q <= '0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            we_q           <= we_d;
            last_gnt_q     <= last_gnt_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
            ram_addr_bus_q <= ram_addr_bus_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            busy_q         <= busy_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign ram_addr_bus = ram_addr_bus_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM on its bus side.
module tb_ram_arbiter;

   localparam logic [3:0] tbRamCode  = 4'h2;
   localparam logic [3:0] tbNoneCode = 4'h0;
   localparam logic [7:0] busWrite   = {tbNoneCode, tbRamCode};
   localparam logic [7:0] busRead    = {tbRamCode, tbNoneCode};

   logic       clk;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       ack0, ack1;
   logic [7:0] rdata0, rdata1;
   logic [7:0] ram_addr_bus, ram_addr, ram_wdata, ram_rdata;
   logic       busy;

   logic [7:0] mem [256];

   int checkCount = 0;
   int errorCount = 0;

   ram_arbiter #(
      .DATA_WIDTH     (8),
      .RAM_ADDR_WIDTH (8),
      .RAM_CODE       (tbRamCode),
      .NONE_CODE      (tbNoneCode)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .ack0         (ack0),
      .ack1         (ack1),
      .rdata0       (rdata0),
      .rdata1       (rdata1),
      .ram_addr_bus (ram_addr_bus),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .busy         (busy)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, write on the edge when the write code is present
   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_addr_bus[3:0] == tbRamCode) mem[ram_addr] <= ram_wdata;
   end

   // Hard stop in case something hangs despite the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: observed hang, expected completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one transaction on a port; called and returns at #1 after a rising edge
   task automatic applyStimulus(input bit port, input logic we, input logic [7:0] addr,
                                input logic [7:0] data, input logic [7:0] expRdata);
      int n;
      bit got;
      logic ackV;
      logic [7:0] rdV;
      if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
      else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         ackV = port ? ack1 : ack0;
         rdV  = port ? rdata1 : rdata0;
         if (n == 2) begin
            checkOutput("accessBus", ram_addr_bus, we ? busWrite : busRead);
            checkOutput("accessAddr", ram_addr, addr);
            if (we) checkOutput("accessWdata", ram_wdata, data);
         end
         if (ackV) begin
            got = 1'b1;
            checkOutput("ackLatency", n, 3);
            checkOutput("ackRdata", rdV, we ? 8'h00 : expRdata);
         end
      end
      if (!got) checkOutput("ackTimeout", 0, 1);
      @(posedge clk);
      #1;
      if (port) req1 = 1'b0; else req0 = 1'b0;
   endtask

   initial begin
      int ack0At, ack1At, ack0Cnt, ack1Cnt, idx;
      logic expA0, expA1;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

      // Reset and ten idle cycles: everything quiet
      applyReset();
      checkOutput("resetOutputs", {ack0, ack1, busy, rdata0, rdata1, ram_addr_bus, ram_addr, ram_wdata}, 0);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checkOutput("idleBus", ram_addr_bus, 8'h00);
         checkOutput("idleOutputs", {ack0, ack1, busy, rdata0, rdata1, ram_addr, ram_wdata}, 0);
      end

      // Single write then read on port 0
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b1, 8'h05, 8'hA5, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h05, 8'h00, 8'hA5);

      // Simultaneous writes from reset: port 0 wins the first tie
      applyReset();
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 8'h22;
      ack0At = 0; ack1At = 0; ack0Cnt = 0; ack1Cnt = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (ack0) begin ack0Cnt++; if (ack0At == 0) ack0At = n; end
         if (ack1) begin ack1Cnt++; if (ack1At == 0) ack1At = n; end
         if (n == 2) checkOutput("tieBus0", {ram_addr_bus, ram_addr}, {busWrite, 8'h01});
         if (n == 4) checkOutput("tieBus1", {ram_addr_bus, ram_addr}, {busWrite, 8'h02});
         @(posedge clk); #1;
         if (ack0At == n) req0 = 1'b0;
         if (ack1At == n) req1 = 1'b0;
      end
      checkOutput("tieAck0Cycle", ack0At, 3);
      checkOutput("tieAck1Cycle", ack1At, 5);
      checkOutput("tieAckCounts", {ack0Cnt[15:0], ack1Cnt[15:0]}, {16'd1, 16'd1});
      applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, 8'h11);
      applyStimulus(1'b1, 1'b0, 8'h02, 8'h00, 8'h22);

      // Both ports hold read requests: strict alternation, busy stays high
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         idx   = (n - 3) / 2;
         expA0 = (n >= 3) && (n % 2 == 1) && (idx % 2 == 0);
         expA1 = (n >= 3) && (n % 2 == 1) && (idx % 2 == 1);
         checkOutput("altAcks", {ack0, ack1}, {expA0, expA1});
         checkOutput("altRdata", {rdata0, rdata1}, {expA0 ? 8'h11 : 8'h00, expA1 ? 8'h22 : 8'h00});
         if (n >= 2) checkOutput("altBusy", busy, 1'b1);
         @(posedge clk); #1;
         if (n == 15) req0 = 1'b0;
         if (n == 17) req1 = 1'b0;
      end

      // Port 1 back-to-back reads: each sees a one-cycle idle gap (latency 3 again)
      applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5);
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 8'h11);
      applyStimulus(1'b1, 1'b0, 8'h02, 8'h00, 8'h22);
      applyStimulus(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5);

      // Request dropped right after being sampled still completes
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h03; wdata1 = 8'h33;
      @(posedge clk); #1;
      req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("droppedReqAck", ack1, 1'b1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 8'h03, 8'h00, 8'h33);

      // Reset asserted during an ACCESS read aborts it with no ack
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortAccessBus", ram_addr_bus, busRead);
      rst_n = 1'b0;
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("abortOutputs", {ack0, ack1, busy, rdata0, rdata1, ram_addr_bus, ram_addr, ram_wdata}, 0);
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checkOutput("abortNoAck", {ack0, ack1, busy}, 3'b000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single on-chip RAM between the core datapath (requester 0) and the debug/DMA port (requester 1). It sits directly in front of `ram` and drives its bus-code, address and write-data inputs from registered state. Each requester receives its own acknowledge and read-data return. Requests use a level request / one-cycle acknowledge handshake with round-robin fairness.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data width; matches the `define.v` data width.
- `RAM_ADDR_WIDTH`, 8, RAM word-address width.
- `RAM_CODE`, `RAM` from `define.v`, 4-bit unit code selecting the RAM on the bus.
- `NONE_CODE`, 4'h0, idle unit code.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req0`, `req1`  in  1  access request, level; held until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1`  in  RAM_ADDR_WIDTH  word address; stable while req is high.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data; stable while req is high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_WIDTH  read data; valid only while the matching ack is high, else 0.
- `ram_addr_bus`  out  DATA_WIDTH  to ram `addr_bus`: {read code, write code}.
- `ram_addr`  out  RAM_ADDR_WIDTH  to ram `ram_addr`.
- `ram_wdata`  out  DATA_WIDTH  to ram `data_bus_in`.
- `ram_rdata`  in  DATA_WIDTH  from ram `data_bus_out`; combinational read.
- `busy`  out  1  high in ACCESS or RESP.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ACCESS: RAM driven for one cycle.
  - RESP: ack issued for one cycle.
- Arbitration candidates:
  - In IDLE: both requests.
  - In RESP: the requester currently being acked is masked; only the other request counts.
- Grant rule:
  - One candidate: grant it.
  - Two candidates: grant the one not in `last_gnt`.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- On grant:
  - Latch grant id, we, addr and wdata.
  - Set `last_gnt` to the grant id.
  - Go to ACCESS.
- ACCESS cycle outputs:
  - `ram_addr` = latched addr.
  - `ram_wdata` = latched wdata.
  - `ram_addr_bus` = {NONE_CODE, RAM_CODE} for a write, {RAM_CODE, NONE_CODE} for a read.
  - The write commits at the edge that ends ACCESS.
  - For a read, `ram_rdata` is captured into `rdata_q` at that edge.
  - Next state is RESP.
- RESP cycle outputs:
  - `ram_addr_bus` = {NONE_CODE, NONE_CODE}.
  - Granted ack = 1; granted rdata = `rdata_q` for a read, 0 for a write.
  - Next state: ACCESS if a candidate exists (back-to-back), else IDLE.
- Requester rules:
  - Deassert req, or present a new request, in the cycle after its ack.
  - A req held high through RESP is not re-granted in that RESP cycle.
- Idle-cycle outputs: `ram_addr_bus`, `ram_addr` and `ram_wdata` are 0 outside ACCESS.
- Reset values (all outputs and state):
  - State = IDLE; acks = 0; rdata = 0; `ram_*` = 0; `busy` = 0; `last_gnt` = 1.
- Reset mid-operation:
  - `rst_n` low during ACCESS: the RAM still sees that cycle's codes, and a write may commit.
  - No ack is ever issued for an aborted transaction; requesters must re-request.
- Protocol violation: a request deasserted before its ack is not cancelled; the transaction completes and its ack is still issued.

## Timing
- Request sampled at edge k while IDLE → ACCESS in cycle k+1 → ack high in cycle k+2 → IDLE or ACCESS at k+3.
- Latency is 2 cycles from the sample edge to ack.
- Throughput is one access per 2 cycles.
- Both requests held continuously: grants strictly alternate 0,1,0,1; no requester waits more than 4 cycles after its previous ack.
- All outputs are registered; there is no combinational path from req to any output.

## Structure
- FSM state encoding (IDLE/ACCESS/RESP) and the NONE_CODE constant belong in `define.v` alongside the unit codes.
- One natural sub-module: `rr_arb2`. It is a combinational 2-way round-robin picker taking req vector, mask and `last_gnt`, and producing grant valid and id. The FSM and datapath registers stay in `ram_arbiter`.

## Test plan
- Reset, then idle: all outputs 0 and `busy` 0; `ram_addr_bus` = 0x00 for 10 cycles.
- Single write, then read on port 0:
  - Write addr 0x05, data 0xA5: `ram_addr_bus` = {0, RAM_CODE} in ACCESS, `ack0` at k+2.
  - Read addr 0x05: `rdata0` = 0xA5 with `ack0`.
- Simultaneous requests from reset: port 0 writes 0x11 to addr 1, port 1 writes 0x22 to addr 2. Required: port 0 acked first, port 1 acked 2 cycles later; read-back returns 0x11 and 0x22.
- Both requests held with reads for 8 transactions: acks alternate `ack0`/`ack1` every 2 cycles; `busy` stays high throughout.
- Back-to-back on one port: port 1 issues 4 reads immediately after each ack. Required: a 1-cycle IDLE gap between transactions, since the port is masked in RESP; no duplicate acks.
- Reset mid-operation: drive `rst_n` low during an ACCESS read. Required: no ack; all outputs 0 next cycle; state IDLE.
